// File: rtl/fft4_pkg.sv
// Shared types for the fft4 frame sequencer: controller states, sample index, default width.
package fft4_pkg;

  localparam int FFT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAUNCH,
    WAIT,
    DRAIN
  } state_t;

  typedef logic [1:0] idx_t;

endpackage

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer around fft4: gathers four serial samples, launches the core, waits for done
// (with timeout), then drains the four bins serially with a last marker.
module fft4_frame_ctrl
  import fft4_pkg::*;
#(
  parameter int WIDTH   = FFT_WIDTH,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic signed [WIDTH-1:0] fft_in0,
  output logic signed [WIDTH-1:0] fft_in1,
  output logic signed [WIDTH-1:0] fft_in2,
  output logic signed [WIDTH-1:0] fft_in3,
  input  logic signed [WIDTH-1:0] fft_out0,
  input  logic signed [WIDTH-1:0] fft_out1,
  input  logic signed [WIDTH-1:0] fft_out2,
  input  logic signed [WIDTH-1:0] fft_out3,
  input  logic                    clr_err,
  output logic                    err,
  output logic [CNTW-1:0]         frame_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                  state;
  state_t                  state_nx;
  idx_t                    idx;
  logic [TW-1:0]           tmo_cnt;
  logic signed [WIDTH-1:0] in_buf  [4];
  logic signed [WIDTH-1:0] out_buf [4];
  logic                    s_fire;
  logic                    m_fire;
  logic                    tmo_hit;

  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;
  // done in the final WAIT cycle takes priority over the abort
  assign tmo_hit = (state == WAIT) && !fft_done && (tmo_cnt == TW'(TIMEOUT - 1));

  assign fft_in0 = in_buf[0];
  assign fft_in1 = in_buf[1];
  assign fft_in2 = in_buf[2];
  assign fft_in3 = in_buf[3];
  assign m_data  = out_buf[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FILL;
      FILL:    if (s_fire && idx == 2'd3) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT: begin
        if (fft_done)     state_nx = DRAIN;
        else if (tmo_hit) state_nx = FILL;
      end
      DRAIN:   if (m_fire && idx == 2'd3) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == FILL);
    fft_start = (state == LAUNCH);
    m_valid   = (state == DRAIN);
    m_last    = (state == DRAIN) && (idx == 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        in_buf[i]  <= '0;
        out_buf[i] <= '0;
      end
    end else begin
      if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else               tmo_cnt <= '0;

      if (state == FILL && s_fire) begin
        in_buf[idx] <= s_data;
        idx         <= idx + 2'd1;
      end

      if (state == WAIT && fft_done) begin
        out_buf[0] <= fft_out0;
        out_buf[1] <= fft_out1;
        out_buf[2] <= fft_out2;
        out_buf[3] <= fft_out3;
      end

      if (state == DRAIN && m_fire) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) frame_cnt <= frame_cnt + 1'b1;
      end

      if (tmo_hit)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Directed bench for fft4_frame_ctrl with a behavioural fft4 stub (programmable done latency).
module tb_fft4_frame_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data = '0;
  logic                    m_valid;
  logic                    m_ready = 1'b0;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    fft_start;
  logic                    fft_done;
  logic signed [WIDTH-1:0] fft_in0, fft_in1, fft_in2, fft_in3;
  logic signed [WIDTH-1:0] fft_out0, fft_out1, fft_out2, fft_out3;
  logic                    clr_err = 1'b0;
  logic                    err;
  logic [CNTW-1:0]         frame_cnt;

  int total = 0;
  int bad   = 0;

  int                      lat = 1;
  logic                    force_done = 1'b0;
  int                      cd;
  logic signed [WIDTH-1:0] r [4] = '{default: '0};
  int                      n_start = 0;
  int                      n_mvalid = 0;

  logic signed [WIDTH-1:0] in_vec [4];
  logic signed [WIDTH-1:0] got_d  [4];
  logic                    got_l  [4];
  int                      stable_bad;
  int                      sready_bad;

  fft4_frame_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fft_start(fft_start), .fft_done(fft_done),
    .fft_in0(fft_in0), .fft_in1(fft_in1), .fft_in2(fft_in2), .fft_in3(fft_in3),
    .fft_out0(fft_out0), .fft_out1(fft_out1), .fft_out2(fft_out2), .fft_out3(fft_out3),
    .clr_err(clr_err), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Stub packs each complex bin as {re[15:0], im[15:0]}; lat=0 suppresses done.
  function automatic logic signed [WIDTH-1:0] pack(input int re, input int im);
    logic [15:0] a;
    logic [15:0] b;
    a = re[15:0];
    b = im[15:0];
    return {a, b};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) cd <= 0;
    else if (fft_start) begin
      cd   <= lat;
      r[0] <= pack(fft_in0 + fft_in1 + fft_in2 + fft_in3, 0);
      r[1] <= pack(fft_in0 - fft_in2, fft_in3 - fft_in1);
      r[2] <= pack(fft_in0 - fft_in1 + fft_in2 - fft_in3, 0);
      r[3] <= pack(fft_in0 - fft_in2, fft_in1 - fft_in3);
    end else if (cd > 0) cd <= cd - 1;
  end

  assign fft_done = (cd == 1) || force_done;
  assign fft_out0 = r[0];
  assign fft_out1 = r[1];
  assign fft_out2 = r[2];
  assign fft_out3 = r[3];

  always @(posedge clk) begin
    if (fft_start) n_start  <= n_start + 1;
    if (m_valid)   n_mvalid <= n_mvalid + 1;
  end

  task automatic feed(input int gaps, input int budget, output bit ok);
    int k = 0;
    int cyc = 0;
    ok = 1'b1;
    while (k < 4) begin
      @(negedge clk);
      if (cyc >= budget) begin ok = 1'b0; break; end
      cyc++;
      s_valid = (gaps != 0 && (cyc % 2) == 0) ? 1'b0 : 1'b1;
      s_data  = in_vec[k];
      if (s_valid && s_ready) k++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input int budget, output bit ok);
    int n = 0;
    int cyc = 0;
    int st = 0;
    logic signed [WIDTH-1:0] held = '0;
    ok = 1'b1;
    stable_bad = 0;
    sready_bad = 0;
    while (n < 4) begin
      @(negedge clk);
      if (cyc >= budget) begin ok = 1'b0; break; end
      cyc++;
      if (s_ready) sready_bad++;
      if (m_valid && st < stall) begin
        if (st == 0) held = m_data;
        else if (m_data !== held || m_last !== 1'b0) stable_bad++;
        m_ready = 1'b0;
        st++;
      end else begin
        m_ready = 1'b1;
        if (m_valid) begin
          got_d[n] = m_data;
          got_l[n] = m_last;
          n++;
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, m_last, fft_start, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {s_ready, m_valid, m_last, fft_start, err});
    end
    total++;
    if (m_data !== '0 || {fft_in0, fft_in1, fft_in2, fft_in3} !== 128'd0) begin
      bad++; $display("FAIL reset_data: m_data=%0h fft_in0=%0h want 0", m_data, fft_in0);
    end
    total++;
    if (frame_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL sready_idle: got %b want 0", s_ready); end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL sready_first: got %b want 1", s_ready); end
  endtask

  task automatic test_basic;
    logic signed [WIDTH-1:0] exp_b [4] = '{32'h000A0000, 32'hFFFE0002, 32'hFFFE0000, 32'hFFFEFFFE};
    bit ok;
    int s0 = n_start;
    in_vec = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    lat = 1;
    feed(0, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_feed: got timeout want 4 transfers"); end
    total++;
    if (fft_start !== 1'b1 || s_ready !== 1'b0) begin
      bad++; $display("FAIL basic_launch: start=%b ready=%b want 1 0", fft_start, s_ready);
    end
    total++;
    if ({fft_in0, fft_in1, fft_in2, fft_in3} !== {32'sd1, 32'sd2, 32'sd3, 32'sd4}) begin
      bad++; $display("FAIL basic_fft_in: got %0h %0h %0h %0h want 1 2 3 4", fft_in0, fft_in1, fft_in2, fft_in3);
    end
    @(negedge clk);
    total++;
    if (fft_start !== 1'b0) begin bad++; $display("FAIL basic_start_width: got %b want 0", fft_start); end
    collect(0, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_collect: got timeout want 4 outputs"); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_d[i] !== exp_b[i] || got_l[i] !== (i == 3)) begin
        bad++; $display("FAIL basic_x%0d: got %h last=%b want %h last=%b", i, got_d[i], got_l[i], exp_b[i], i == 3);
      end
    end
    total++;
    if (frame_cnt !== 4'd1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL basic_end: cnt=%0d ready=%b want 1 1", frame_cnt, s_ready);
    end
    total++;
    if (n_start - s0 !== 1) begin bad++; $display("FAIL basic_starts: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_gaps_stall;
    logic signed [WIDTH-1:0] exp_b [4] = '{32'h000B0000, 32'hFFFE0001, 32'h000D0000, 32'hFFFEFFFF};
    bit ok;
    in_vec = '{32'sd5, 32'hFFFFFFFF, 32'sd7, 32'sd0};
    lat = 3;
    feed(1, 30, ok);
    total++;
    if (!ok || {fft_in0, fft_in1, fft_in2, fft_in3} !== {32'sd5, 32'hFFFFFFFF, 32'sd7, 32'sd0}) begin
      bad++; $display("FAIL gaps_fft_in: got %0h %0h %0h %0h want 5 ffffffff 7 0", fft_in0, fft_in1, fft_in2, fft_in3);
    end
    collect(10, 40, ok);
    total++;
    if (!ok || stable_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stable_bad); end
    total++;
    if (sready_bad != 0) begin bad++; $display("FAIL gaps_sready: got %0d high cycles want 0", sready_bad); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_d[i] !== exp_b[i] || got_l[i] !== (i == 3)) begin
        bad++; $display("FAIL gaps_x%0d: got %h last=%b want %h last=%b", i, got_d[i], got_l[i], exp_b[i], i == 3);
      end
    end
    total++;
    if (frame_cnt !== 4'd2) begin bad++; $display("FAIL gaps_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_timeout;
    bit ok;
    int early = 0;
    in_vec = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    lat = 0;
    feed(0, 20, ok);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      if (err || m_valid || s_ready) early++;
    end
    total++;
    if (!ok || early != 0) begin bad++; $display("FAIL tmo_early: got %0d bad cycles want 0", early); end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL tmo_set: err=%b ready=%b want 1 1", err, s_ready);
    end
    lat = 1;
    feed(0, 20, ok);
    collect(0, 20, ok);
    total++;
    if (!ok || got_d[0] !== 32'h000A0000 || got_d[3] !== 32'hFFFEFFFE) begin
      bad++; $display("FAIL tmo_next_frame: got %h %h want 000a0000 fffefffe", got_d[0], got_d[3]);
    end
    total++;
    if (err !== 1'b1 || frame_cnt !== 4'd3) begin
      bad++; $display("FAIL tmo_sticky: err=%b cnt=%0d want 1 3", err, frame_cnt);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", err); end
  endtask

  task automatic test_done_at_limit;
    bit ok;
    lat = TIMEOUT;
    feed(0, 20, ok);
    collect(0, 100, ok);
    total++;
    if (!ok || got_d[1] !== 32'hFFFE0002 || got_l[3] !== 1'b1) begin
      bad++; $display("FAIL limit_capture: got %h last=%b want fffe0002 1", got_d[1], got_l[3]);
    end
    total++;
    if (err !== 1'b0 || frame_cnt !== 4'd4) begin
      bad++; $display("FAIL limit_err: err=%b cnt=%0d want 0 4", err, frame_cnt);
    end
  endtask

  task automatic test_clr_vs_timeout;
    bit ok;
    lat = 0;
    feed(0, 20, ok);
    repeat (TIMEOUT - 1) @(negedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (!ok || err !== 1'b1) begin bad++; $display("FAIL clr_vs_tmo: got %b want 1", err); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int ns;
    int nm;
    lat = 0;
    feed(0, 20, ok);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, fft_start, err} !== 4'b0 || fft_in0 !== '0 || frame_cnt !== '0) begin
      bad++; $display("FAIL rst_wait: ctrl=%b in0=%0h cnt=%0d want 0 0 0", {s_ready, m_valid, fft_start, err}, fft_in0, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    ns = n_start;
    nm = n_mvalid;
    @(negedge clk);
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (n_start != ns || n_mvalid != nm || s_ready !== 1'b1) begin
      bad++; $display("FAIL rst_spurious: starts=%0d mvalid=%0d ready=%b want 0 0 1", n_start - ns, n_mvalid - nm, s_ready);
    end
    lat = 1;
    in_vec = '{32'sd5, 32'hFFFFFFFF, 32'sd7, 32'sd0};
    feed(0, 20, ok);
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'h000B0000) begin
      bad++; $display("FAIL rst_drain_pre: valid=%b data=%h want 1 000b0000", m_valid, m_data);
    end
    rst = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
      bad++; $display("FAIL rst_drain: valid=%b data=%h last=%b want 0 0 0", m_valid, m_data, m_last);
    end
    @(negedge clk);
    rst = 1'b1;
    nm = n_mvalid;
    ns = n_start;
    repeat (4) @(negedge clk);
    total++;
    if (n_mvalid != nm || n_start != ns) begin
      bad++; $display("FAIL rst_drain_after: mvalid=%0d starts=%0d want 0 0", n_mvalid - nm, n_start - ns);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    bit all_ok = 1'b1;
    in_vec = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    lat = 1;
    for (int f = 1; f <= 17; f++) begin
      feed(0, 20, ok);
      all_ok &= ok;
      collect(0, 20, ok);
      all_ok &= ok;
      if (f >= 15) begin
        total++;
        if (frame_cnt !== 4'(f % 16)) begin
          bad++; $display("FAIL wrap_f%0d: got %0d want %0d", f, frame_cnt, f % 16);
        end
      end
    end
    total++;
    if (!all_ok) begin bad++; $display("FAIL wrap_flow: got timeout want all frames complete"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps_stall();
    test_timeout();
    test_done_at_limit();
    test_clr_vs_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
